// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage FSM states, opcode constants and datapath widths.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_EXEC,
    S_HALT
  } ifu_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC adder: sequential step, plus the sign-extended word offset when a branch is taken.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [15:0]     imm16_i,
  input  logic            pc_src_i,
  output logic [XLEN-1:0] pc_next_o
);

  logic [XLEN-1:0] offset;

  // Branch offset is a word count, so shift left by two before adding.
  always_comb begin
    offset    = pc_src_i ? {{14{imm16_i[15]}}, imm16_i, 2'b00} : '0;
    pc_next_o = pc_i + PC_STEP + offset;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory, holds the IR and
// applies the control unit's advance/branch/halt decision.
// Optional feature: define IFU_RETIRE_CNT_EN to build the retired-instruction counter;
// otherwise retire_cnt is tied to zero.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        PCWre,
  input  logic        PCSrc,
  input  logic        stall,
  output logic        ir_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] retire_cnt
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] pc_next;
  logic        advance;

  // An instruction retires when EXEC is left towards FETCH.
  assign advance = (state_q == S_EXEC) && !stall && PCWre;

  pc_next_calc u_pc_next_calc (
    .pc_i      (pc_q),
    .imm16_i   (ir_q[15:0]),
    .pc_src_i  (PCSrc),
    .pc_next_o (pc_next)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stall has priority over the PCWre decision in EXEC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (stall) begin
          state_d = S_EXEC;
        end else if (!PCWre) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    imem_en  = 1'b0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      S_FETCH: imem_en  = 1'b1;
      S_EXEC:  ir_valid = 1'b1;
      S_HALT:  halted   = 1'b1;
      default: ;
    endcase
  end

  // PC and IR; the IR captures the memory word on the edge leaving FETCH.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
    end else begin
      if (advance) begin
        pc_q <= pc_next;
      end
      if (state_q == S_FETCH) begin
        ir_q <= imem_rdata;
      end
    end
  end

`ifdef IFU_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      retire_cnt_q <= '0;
    end else if (advance) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = '0;
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm16     = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of fetch/execute vectors plus hand-written
// stall, halt, asynchronous-reset and retire-count sequences.
module tb_instr_fetch;
  import cpu_pkg::*;

`ifdef IFU_RETIRE_CNT_EN
  localparam bit RetEn = 1'b1;
`else
  localparam bit RetEn = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        PCWre;
  logic        PCSrc;
  logic        stall;
  logic        ir_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] retire_cnt;

  logic [31:0] mem [64];
  int          checks;
  int          failures;
  int          retired;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .PCWre      (PCWre),
    .PCSrc      (PCSrc),
    .stall      (stall),
    .ir_valid   (ir_valid),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm16      (imm16),
    .pc         (pc),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  assign imem_rdata = mem[imem_addr[7:2]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc_at;
    logic [31:0] word;
    logic        wre;
    logic        src;
    logic        fetch_stall;
    logic [31:0] pc_next;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_retire();
    return RetEn ? retired : 32'd0;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " ir_valid"}, {31'd0, ir_valid}, 32'd0);
    check({tag, " imem_en"}, {31'd0, imem_en}, 32'd0);
    check({tag, " halted"}, {31'd0, halted}, 32'd0);
    check({tag, " retire_cnt"}, retire_cnt, 32'd0);
    check({tag, " opcode"}, {26'd0, opcode}, 32'd0);
    check({tag, " imm16"}, {16'd0, imm16}, 32'd0);
  endtask

  // Entered one cycle into FETCH (sampled #1 after the edge); leaves one cycle after EXEC.
  task automatic run_instr(input logic [31:0] pc_at, input logic [31:0] word, input logic wre,
                           input logic src, input logic fstall, input logic [31:0] pc_next);
    mem[pc_at[7:2]] = word;
    check("fetch imem_en", {31'd0, imem_en}, 32'd1);
    check("fetch imem_addr", imem_addr, pc_at);
    stall = fstall;
    PCWre = 1'b0;
    PCSrc = 1'b0;
    @(posedge CLK); #1;
    stall = 1'b0;
    check("exec ir_valid", {31'd0, ir_valid}, 32'd1);
    check("exec opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    check("exec rs/rt/rd", {17'd0, rs, rt, rd}, {17'd0, word[25:11]});
    check("exec imm16", {16'd0, imm16}, {16'd0, word[15:0]});
    PCWre = wre;
    PCSrc = src;
    @(posedge CLK); #1;
    if (wre) begin
      retired++;
      check("next pc", pc, pc_next);
      check("back to fetch", {31'd0, imem_en}, 32'd1);
    end else begin
      check("halt halted", {31'd0, halted}, 32'd1);
      check("halt pc", pc, pc_at);
      check("halt imem_en", {31'd0, imem_en}, 32'd0);
      check("halt ir_valid", {31'd0, ir_valid}, 32'd0);
    end
    check("retire_cnt", retire_cnt, exp_retire());
  endtask

  initial begin
    logic [31:0] w_add, w_add2, w_halt;
    checks   = 0;
    failures = 0;
    retired  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    w_add  = {OP_ADD, 5'd1, 5'd2, 5'd3, 11'h020};
    w_add2 = {OP_ADD, 5'd5, 5'd6, 5'd4, 11'h020};
    w_halt = {OP_HALT, 26'd0};

    vecs[0] = '{32'd0,  w_add,                            1'b1, 1'b0, 1'b0, 32'd4};
    vecs[1] = '{32'd4,  {OP_ADD, 5'd2, 5'd3, 5'd1, 11'h020}, 1'b1, 1'b0, 1'b0, 32'd8};
    vecs[2] = '{32'd8,  {OP_BEQ, 5'd1, 5'd2, 16'h0003},   1'b1, 1'b1, 1'b0, 32'd24};
    vecs[3] = '{32'd24, 32'h0000_0000,                    1'b1, 1'b0, 1'b1, 32'd28};
    vecs[4] = '{32'd28, {OP_BEQ, 5'd0, 5'd0, 16'hFFFA},   1'b1, 1'b1, 1'b0, 32'd8};
    vecs[5] = '{32'd8,  {OP_BEQ, 5'd1, 5'd2, 16'hFFFE},   1'b1, 1'b1, 1'b0, 32'd4};
    vecs[6] = '{32'd4,  {OP_BEQ, 5'd1, 5'd2, 16'h0005},   1'b1, 1'b0, 1'b0, 32'd8};
    vecs[7] = '{32'd8,  w_add,                            1'b1, 1'b0, 1'b0, 32'd12};

    RST   = 1'b0;
    PCWre = 1'b1;
    PCSrc = 1'b0;
    stall = 1'b0;
    mem[0] = w_add;
    #23;
    check_reset_values("reset");

    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("cycle1 ir_valid", {31'd0, ir_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].pc_at, vecs[i].word, vecs[i].wre, vecs[i].src,
                vecs[i].fetch_stall, vecs[i].pc_next);
    end

    // Stall held three cycles in EXEC, with PCWre=1 present.
    mem[3] = w_add2;
    @(posedge CLK); #1;
    stall = 1'b1;
    PCWre = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("stall pc", pc, 32'd12);
      check("stall ir_valid", {31'd0, ir_valid}, 32'd1);
      check("stall rd", {27'd0, rd}, 32'd4);
      check("stall retire_cnt", retire_cnt, exp_retire());
    end
    stall = 1'b0;
    @(posedge CLK); #1;
    retired++;
    check("post-stall pc", pc, 32'd16);
    check("post-stall retire_cnt", retire_cnt, exp_retire());

    run_instr(32'd16, {OP_BEQ, 5'd0, 5'd0, 16'hFFFE}, 1'b1, 1'b1, 1'b0, 32'd12);
    run_instr(32'd12, w_halt, 1'b0, 1'b0, 1'b0, 32'd12);

    // Halt is sticky regardless of control inputs.
    PCWre = 1'b1;
    PCSrc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      check("sticky halted", {31'd0, halted}, 32'd1);
      check("sticky pc", pc, 32'd12);
      check("sticky imem_en", {31'd0, imem_en}, 32'd0);
    end

    // Asynchronous reset in the middle of EXEC at pc=40.
    RST = 1'b0;
    #12;
    RST = 1'b1;
    retired = 0;
    mem[0]  = {OP_BEQ, 5'd0, 5'd0, 16'h0009};
    @(posedge CLK); #1;
    run_instr(32'd0, mem[0], 1'b1, 1'b1, 1'b0, 32'd40);
    mem[10] = {6'b100011, 5'd7, 5'd8, 16'h1234};
    @(posedge CLK); #1;
    check("pre-reset ir_valid", {31'd0, ir_valid}, 32'd1);
    check("pre-reset opcode", {26'd0, opcode}, 32'h23);
    #2;
    RST = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge CLK);
    RST = 1'b1;
    retired = 0;

    // Five instructions then halt.
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      run_instr(32'(i * 4), w_add, 1'b1, 1'b0, 1'b0, 32'(i * 4 + 4));
    end
    run_instr(32'd20, w_halt, 1'b0, 1'b0, 1'b0, 32'd20);
    check("final retire_cnt", retire_cnt, RetEn ? 32'd5 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
